lap_frame_writer: RTL and testbench
===================================

// Module: lap_frame_writer
// PURPOSE
//  Back end of the 3x3 Laplacian pipeline: takes the adder-tree result stream,
//  converts each 16-bit signed sum to an 8-bit pixel, zeroes the frame border and
//  writes the frame raster-order into the output BRAM through its write port.
//  Runs one frame per start pulse and signals completion to the frame controller.
// PARAMETERS
//  IMG_W     130    frame width in pixels
//  IMG_H     130    frame height in pixels
//  ADDR_W    15     output BRAM address width (must hold IMG_W*IMG_H-1)
//  SKIP_CNT  131    valid samples discarded after start (window-centre alignment)
//  ABS_MODE  0      0: clamp signed sum to [0,255]; 1: clamp |sum| to [0,255]
// PORTS
//  clk        in   1       single clock, all logic posedge
//  reset      in   1       synchronous, active-high
//  start      in   1       one-cycle pulse; begins a frame when idle
//  in_valid   in   1       in_data valid this cycle
//  in_data    in   16      adder-tree result, two's complement
//  wr_en      out  1       BRAM write enable (web)
//  wr_addr    out  ADDR_W  BRAM write address (addrb)
//  wr_data    out  8       BRAM write data (dinb)
//  busy       out  1       high from accepted start until frame_done
//  frame_done out  1       one-cycle pulse after final write
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE, row/col/skip counters 0.
//  - FSM: IDLE -start-> SKIP (SKIP_CNT>0) or WRITE (SKIP_CNT=0);
//    SKIP -SKIP_CNT-th valid-> WRITE; WRITE -valid at row=IMG_H-1,col=IMG_W-1-> DONE;
//    DONE -> IDLE after one cycle.
//  - start ignored unless IDLE; in_valid ignored in IDLE and DONE.
//  - SKIP: counts valid samples only; produces no writes.
//  - WRITE: each in_valid produces exactly one write, latency 1 cycle:
//    wr_en=1, wr_addr=row*IMG_W+col (running counter, no multiplier),
//    wr_data = pixel; wr_en=0 on any cycle without in_valid. No backpressure.
//  - Border: row 0, row IMG_H-1, col 0, col IMG_W-1 -> wr_data=0, sample consumed.
//  - Conversion (ABS_MODE=0): in_data<0 ->0; >255 ->255; else in_data[7:0].
//    ABS_MODE=1: magnitude first (-32768 -> 255), then same clamp.
//  - col wraps IMG_W-1->0 with row+1; after last pixel counters return to 0.
//  - frame_done=1 in DONE cycle (cycle after final wr_en); busy drops same cycle.
//  - start coincident with frame_done: ignored (FSM not yet IDLE).
//  - Reset mid-frame: next cycle wr_en=0, busy=0, no frame_done, IDLE.
// STRUCTURE
//  - Package lap_pkg: IMG_W/IMG_H defaults, state enum {IDLE,SKIP,WRITE,DONE},
//    PIX_MAX=255 constant; shared with the window/line-buffer block.
//  - Sub-module sat_u8: combinational 16b signed -> 8b clamp with ABS_MODE;
//    FSM, counters and output registers stay in lap_frame_writer.
// TESTING (bench uses IMG_W=4, IMG_H=4, SKIP_CNT=2 unless stated)
//  - Reset: after reset, wr_en=0, busy=0, frame_done=0; start then 2 valids -> no writes.
//  - Full frame: start, 18 valids data=k -> 16 writes addr 0..15; interior addrs
//    5,6,9,10 carry 7,8,11,12; border addrs carry 0; frame_done one cycle after addr 15.
//  - Clamp: interior samples -5,300,255,-32768 -> 0,255,255,0; ABS_MODE=1 -> 5,255,255,255.
//  - Gapped valid: in_valid toggling every other cycle -> writes only on cycle after
//    each valid, addresses contiguous, same final data as full-frame case.
//  - Start while busy and at frame_done: second start ignored, no address restart;
//    start one cycle later (IDLE) begins a new frame at addr 0.
//  - Reset after 7 writes: wr_en=0 next cycle, no frame_done; new start restarts at addr 0.

Source files
------------

// File: rtl/lap_pkg.sv
// Shared definitions for the 3x3 Laplacian pipeline: frame geometry defaults,
// writer FSM state codes and the 8-bit pixel ceiling.
package lap_pkg;

    localparam int IMG_W_DEF = 130;
    localparam int IMG_H_DEF = 130;

    localparam logic [7:0] PIX_MAX = 8'd255;

    typedef logic [1:0] state_t;

    localparam state_t IDLE  = 2'd0;
    localparam state_t SKIP  = 2'd1;
    localparam state_t WRITE = 2'd2;
    localparam state_t DONE  = 2'd3;

endpackage

// File: rtl/sat_u8.sv
// Combinational conversion of a signed 16-bit adder-tree sum to an 8-bit pixel,
// optionally taking the magnitude before clamping to [0, PIX_MAX].
module sat_u8
    import lap_pkg::*;
#(
    parameter int ABS_MODE = 0
) (
    input  logic signed [15:0] sum_in,
    output logic        [7:0]  pix_out
);

    // Widened by one bit so that negating -32768 cannot overflow.
    function automatic logic [7:0] sat_pix(input logic signed [15:0] x, input logic abs_en);
        logic signed [16:0] v;
        v = {x[15], x};
        if (abs_en && (v < 0)) begin
            v = -v;
        end
        if (v < 0) begin
            return 8'd0;
        end else if (v > 17'sd255) begin
            return PIX_MAX;
        end else begin
            return v[7:0];
        end
    endfunction

    always_comb begin
        pix_out = sat_pix(sum_in, ABS_MODE != 0);
    end

endmodule

// File: rtl/lap_frame_writer.sv
// Writes one Laplacian frame per start pulse into the output BRAM: drops the
// alignment samples, converts each sum to a pixel, zeroes the border.
module lap_frame_writer
    import lap_pkg::*;
#(
    parameter int IMG_W    = IMG_W_DEF,
    parameter int IMG_H    = IMG_H_DEF,
    parameter int ADDR_W   = 15,
    parameter int SKIP_CNT = 131,
    parameter int ABS_MODE = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [15:0]       in_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              busy,
    output logic              frame_done
);

    localparam int CW = 16;

    state_t            state_q, state_d;
    logic [CW-1:0]     row_q, row_d;
    logic [CW-1:0]     col_q, col_d;
    logic [CW-1:0]     skip_q, skip_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              last_q, last_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]        wr_data_q, wr_data_d;

    logic [7:0] pix;
    logic       border;
    logic       col_end;
    logic       row_end;

    sat_u8 #(.ABS_MODE(ABS_MODE)) u_sat (
        .sum_in  (in_data),
        .pix_out (pix)
    );

    assign col_end = (col_q == CW'(IMG_W - 1));
    assign row_end = (row_q == CW'(IMG_H - 1));
    assign border  = (row_q == '0) || row_end || (col_q == '0) || col_end;

    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        col_d     = col_q;
        skip_d    = skip_q;
        addr_d    = addr_q;
        last_d    = last_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = (SKIP_CNT > 0) ? SKIP : WRITE;
                    row_d   = '0;
                    col_d   = '0;
                    skip_d  = '0;
                    addr_d  = '0;
                end
            end
            SKIP: begin
                if (in_valid) begin
                    if (skip_q == CW'(SKIP_CNT - 1)) begin
                        state_d = WRITE;
                        skip_d  = '0;
                    end else begin
                        skip_d = skip_q + 1'b1;
                    end
                end
            end
            WRITE: begin
                // Hold WRITE for the cycle that presents the final write so
                // frame_done lands one cycle after it.
                if (last_q) begin
                    state_d = DONE;
                    last_d  = 1'b0;
                end else if (in_valid) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = addr_q;
                    wr_data_d = border ? 8'd0 : pix;
                    if (col_end) begin
                        col_d = '0;
                        if (row_end) begin
                            row_d  = '0;
                            addr_d = '0;
                            last_d = 1'b1;
                        end else begin
                            row_d  = row_q + 1'b1;
                            addr_d = addr_q + 1'b1;
                        end
                    end else begin
                        col_d  = col_q + 1'b1;
                        addr_d = addr_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            row_q     <= '0;
            col_q     <= '0;
            skip_q    <= '0;
            addr_q    <= '0;
            last_q    <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            col_q     <= col_d;
            skip_q    <= skip_d;
            addr_q    <= addr_d;
            last_q    <= last_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign busy       = (state_q == SKIP) || (state_q == WRITE);
    assign frame_done = (state_q == DONE);

endmodule

// File: tb/tb_lap_frame_writer.sv
// Bench for lap_frame_writer on a 4x4 frame with two alignment samples; one
// instance per conversion mode, both checked against a transaction-level model.
module tb_lap_frame_writer;

    localparam int W    = 4;
    localparam int H    = 4;
    localparam int AW   = 4;
    localparam int SKIP = 2;
    localparam int NPIX = W * H;
    localparam int NSMP = NPIX + SKIP;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic start = 1'b0;
    logic in_valid = 1'b0;
    logic [15:0] in_data = '0;

    logic          wr_en0, wr_en1;
    logic [AW-1:0] wr_addr0, wr_addr1;
    logic [7:0]    wr_data0, wr_data1;
    logic          busy0, busy1;
    logic          done0, done1;

    int n_pass = 0;
    int n_tot  = 0;

    // Frame model: 0 idle, 1 frame running, 2 final write shown, 3 done cycle.
    int phase = 0;
    int seen  = 0;
    logic [15:0] samp [NSMP];

    always #5 clk = ~clk;

    lap_frame_writer #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW), .SKIP_CNT(SKIP), .ABS_MODE(0)) u_dut0 (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
        .wr_en(wr_en0), .wr_addr(wr_addr0), .wr_data(wr_data0), .busy(busy0), .frame_done(done0)
    );

    lap_frame_writer #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW), .SKIP_CNT(SKIP), .ABS_MODE(1)) u_dut1 (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
        .wr_en(wr_en1), .wr_addr(wr_addr1), .wr_data(wr_data1), .busy(busy1), .frame_done(done1)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        n_tot++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int to_pix(input logic [15:0] d, input bit abs_en);
        int v;
        v = int'($signed(d));
        if (abs_en && v < 0) v = -v;
        if (v < 0) return 0;
        if (v > 255) return 255;
        return v;
    endfunction

    // Drive one cycle of inputs, advance the model, compare both instances.
    task automatic step(input logic st, input logic v, input logic [15:0] d);
        bit e_en;
        int e_addr, e_d0, e_d1, pixn, r, c;
        bit bord;
        @(negedge clk);
        start = st; in_valid = v; in_data = d;
        @(posedge clk);
        #1;
        e_en = 0; e_addr = 0; e_d0 = 0; e_d1 = 0;
        case (phase)
            0: if (st) begin phase = 1; seen = 0; end
            1: if (v) begin
                if (seen >= SKIP) begin
                    pixn = seen - SKIP;
                    r = pixn / W;
                    c = pixn % W;
                    bord = (r == 0) || (r == H - 1) || (c == 0) || (c == W - 1);
                    e_en = 1;
                    e_addr = pixn;
                    e_d0 = bord ? 0 : to_pix(d, 0);
                    e_d1 = bord ? 0 : to_pix(d, 1);
                    if (pixn == NPIX - 1) phase = 2;
                end
                seen++;
            end
            2: phase = 3;
            default: phase = 0;
        endcase
        chk("wr_en0", int'(wr_en0), int'(e_en));
        chk("wr_en1", int'(wr_en1), int'(e_en));
        chk("busy", int'(busy0), int'(phase == 1 || phase == 2));
        chk("frame_done", int'(done0), int'(phase == 3));
        chk("busy_abs", int'(busy1), int'(phase == 1 || phase == 2));
        chk("frame_done_abs", int'(done1), int'(phase == 3));
        if (e_en) begin
            chk("wr_addr0", int'(wr_addr0), e_addr);
            chk("wr_addr1", int'(wr_addr1), e_addr);
            chk("wr_data0", int'(wr_data0), e_d0);
            chk("wr_data1", int'(wr_data1), e_d1);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
        @(posedge clk);
        #1;
        phase = 0; seen = 0;
        chk("rst_wr_en", int'(wr_en0 | wr_en1), 0);
        chk("rst_busy", int'(busy0 | busy1), 0);
        chk("rst_done", int'(done0 | done1), 0);
        chk("rst_addr", int'(wr_addr0), 0);
        chk("rst_data", int'(wr_data0), 0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic feed_frame(input bit gap);
        step(1'b1, 1'b0, 16'd0);
        for (int i = 0; i < NSMP; i++) begin
            step(1'b0, 1'b1, samp[i]);
            if (gap) step(1'b0, 1'b0, 16'($urandom));
        end
        step(1'b0, 1'b0, 16'd0);
        step(1'b0, 1'b0, 16'd0);
        step(1'b0, 1'b0, 16'd0);
    endtask

    function automatic logic [15:0] rand_sample();
        case ($urandom_range(0, 5))
            0: return 16'h8000;
            1: return 16'($urandom_range(0, 255));
            2: return 16'(-$urandom_range(1, 300));
            3: return 16'($urandom_range(250, 260));
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        do_reset();
        do_reset();

        // Ramp frame: data equals sample index.
        for (int i = 0; i < NSMP; i++) samp[i] = 16'(i);
        feed_frame(1'b0);

        // Clamp corners on the four interior pixels.
        for (int i = 0; i < NSMP; i++) samp[i] = 16'($urandom_range(0, 400));
        samp[7]  = 16'hFFFB;
        samp[8]  = 16'd300;
        samp[11] = 16'd255;
        samp[12] = 16'h8000;
        feed_frame(1'b0);

        // Gapped valid with the ramp.
        for (int i = 0; i < NSMP; i++) samp[i] = 16'(i);
        feed_frame(1'b1);

        // Start while busy, start during frame_done, then start once idle.
        step(1'b1, 1'b0, 16'd0);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, samp[i]);
        step(1'b1, 1'b1, samp[6]);
        for (int i = 7; i < NSMP; i++) step(1'b0, 1'b1, samp[i]);
        step(1'b0, 1'b0, 16'd0);
        step(1'b1, 1'b0, 16'd0);
        step(1'b1, 1'b0, 16'd0);
        for (int i = 0; i < NSMP; i++) step(1'b0, 1'b1, 16'(i + 40));
        step(1'b0, 1'b0, 16'd0);
        step(1'b0, 1'b0, 16'd0);

        // Reset after seven writes, then a fresh frame.
        step(1'b1, 1'b0, 16'd0);
        for (int i = 0; i < SKIP + 7; i++) step(1'b0, 1'b1, 16'(i));
        do_reset();
        step(1'b0, 1'b0, 16'd0);
        for (int i = 0; i < NSMP; i++) samp[i] = rand_sample();
        feed_frame(1'b0);

        // Randomized traffic including stray starts and idle valids.
        for (int n = 0; n < 3000; n++) begin
            step(($urandom_range(0, 7) == 0), ($urandom_range(0, 3) != 0), rand_sample());
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
